// File: rtl/iter_calc_core_if.sv
// Handshake bundle for iter_calc_core.
//   master : drives start/op/a/b, observes busy/done/result/err (wrapper side)
//   slave  : the calculator core
// Ports:
//   start  request, sampled only while the core is idle
//   op     3-bit opcode, sampled with start
//   a, b   WIDTH-bit unsigned operands, sampled with start
//   busy   operation in progress
//   done   one-cycle completion pulse
//   result 2*WIDTH-bit registered result
//   err    registered error flag, valid with done
interface iter_calc_core_if #(
  parameter int WIDTH = 16
);
  logic               start;
  logic [2:0]         op;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] result;
  logic               err;

  modport master (
    output start, op, a, b,
    input  busy, done, result, err
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, err
  );
endinterface

// File: rtl/iter_calc_core.sv
// Calculator datapath: single-cycle add/sub/logic ops plus iterative
// shift-add multiply and restoring divide behind a start/busy/done handshake.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    iter_calc_core_if.slave (start/op/a/b in, busy/done/result/err out)
//
// state | meaning
// IDLE  | waiting for start; result/err hold the last completed operation
// EXEC  | single-cycle op, DIV by zero or reserved op; writes result next edge
// ITER  | one multiply/divide step per edge, cnt counts remaining steps
// FIN   | copies the iterative work register into result
module iter_calc_core #(
  parameter int WIDTH = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  iter_calc_core_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;

  typedef enum logic [1:0] {IDLE, EXEC, ITER, FIN} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt;
  logic [2:0]           op_q;
  logic [WIDTH-1:0]     a_q, b_q;
  logic [2*WIDTH-1:0]   work, work_step;
  logic [2*WIDTH-1:0]   result_q, exec_res;
  logic                 err_q, exec_err, done_q, busy_c;
  logic                 iter_op;
  logic [WIDTH:0]       mul_sum, div_shift, div_diff, sum_w, sub_w;

  assign iter_op = (bus.op == OP_MUL) || ((bus.op == OP_DIV) && (bus.b != '0));

  // work holds {hi, lo}: for MUL the partial product high half and the
  // remaining multiplier bits; for DIV the partial remainder and the
  // dividend bits being shifted out / quotient bits being shifted in.
  always_comb begin
    mul_sum   = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, a_q} : '0);
    div_shift = {work[2*WIDTH-1:WIDTH], work[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_q};
    if (op_q == OP_MUL)
      work_step = {mul_sum, work[WIDTH-1:1]};
    else if (!div_diff[WIDTH])   // no borrow: keep the subtraction
      work_step = {div_diff[WIDTH-1:0], work[WIDTH-2:0], 1'b1};
    else
      work_step = {div_shift[WIDTH-1:0], work[WIDTH-2:0], 1'b0};
  end

  always_comb begin
    sum_w    = {1'b0, a_q} + {1'b0, b_q};
    sub_w    = {1'b0, a_q} - {1'b0, b_q};  // bit WIDTH is the borrow
    exec_res = '0;
    exec_err = 1'b0;
    case (op_q)
      OP_ADD:  exec_res = {{(WIDTH-1){1'b0}}, sum_w};
      OP_SUB:  exec_res = {{(WIDTH-1){1'b0}}, sub_w};
      OP_DIV:  begin  // only divide-by-zero reaches EXEC
        exec_res = {a_q, {WIDTH{1'b1}}};
        exec_err = 1'b1;
      end
      OP_AND:  exec_res = {{WIDTH{1'b0}}, a_q & b_q};
      OP_OR:   exec_res = {{WIDTH{1'b0}}, a_q | b_q};
      OP_XOR:  exec_res = {{WIDTH{1'b0}}, a_q ^ b_q};
      OP_MUL:  exec_res = '0;
      default: exec_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = iter_op ? ITER : EXEC;
      EXEC:    state_nxt = IDLE;
      ITER:    if (cnt == CW'(1)) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_c = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      work     <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          op_q <= bus.op;
          a_q  <= bus.a;
          b_q  <= bus.b;
          work <= {{WIDTH{1'b0}}, (bus.op == OP_DIV) ? bus.a : bus.b};
          cnt  <= CW'(WIDTH);
        end
        EXEC: begin
          result_q <= exec_res;
          err_q    <= exec_err;
          done_q   <= 1'b1;
        end
        ITER: begin
          work <= work_step;
          cnt  <= cnt - CW'(1);
        end
        FIN: begin
          result_q <= work;
          err_q    <= 1'b0;
          done_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = busy_c;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.err    = err_q;
endmodule

// File: tb/tb_iter_calc_core.sv
module tb_iter_calc_core;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  iter_calc_core_if #(.WIDTH(W)) bus ();
  iter_calc_core #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [15:0] res;
    logic        err;
    int          edge_n;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_pass = 0;
  int edge_cnt = 0;
  int n_done = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [16:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] r;
    logic        e;
    r = '0;
    e = 1'b0;
    case (op)
      3'd0: r = {8'h00, a} + {8'h00, b};
      3'd1: begin r[7:0] = a - b; r[8] = (a < b); end
      3'd2: r = {8'h00, a} * {8'h00, b};
      3'd3: if (b == 8'h00) begin r = {a, 8'hFF}; e = 1'b1; end
            else begin r[15:8] = a % b; r[7:0] = a / b; end
      3'd4: r[7:0] = a & b;
      3'd5: r[7:0] = a | b;
      3'd6: r[7:0] = a ^ b;
      default: e = 1'b1;
    endcase
    return {e, r};
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      n_done++;
      check("busy_with_done", bus.busy, 0);
      if (sb.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", bus.result, e.res);
        check("err", bus.err, e.err);
        check("done_edge", edge_cnt, e.edge_n);
      end
    end
  end

  // Drives one request, waits for the accepting edge and queues the expected completion.
  task automatic do_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    logic [16:0] m;
    bus.start = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op = 3'($urandom);
    bus.a = 8'($urandom);
    bus.b = 8'($urandom);
    check("busy_after_accept", bus.busy, 1);
    m = model(op, a, b);
    e.res = m[15:0];
    e.err = m[16];
    e.edge_n = edge_cnt + (((op == 3'd2) || (op == 3'd3 && b != 8'h00)) ? W + 1 : 1);
    sb.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    check("drain_queue_empty", sb.size(), 0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op = '0;
    bus.a = '0;
    bus.b = '0;
    #12;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_result", bus.result, 0);
    check("rst_err", bus.err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(3'd0, 8'hFF, 8'h01); drain();
    do_op(3'd1, 8'h03, 8'h05); drain();
    do_op(3'd2, 8'd200, 8'd3); drain();
    do_op(3'd2, 8'hFF, 8'hFF); drain();
    do_op(3'd3, 8'd200, 8'd7); drain();
    do_op(3'd3, 8'd5, 8'd9); drain();
    do_op(3'd3, 8'h42, 8'h00); drain();
    do_op(3'd0, 8'h01, 8'h01); drain();
    do_op(3'd4, 8'hF0, 8'h3C); drain();
    do_op(3'd5, 8'hF0, 8'h3C); drain();
    do_op(3'd6, 8'hF0, 8'h3C); drain();
    do_op(3'd7, 8'h12, 8'h34); drain();
    do_op(3'd3, 8'hFF, 8'h01); drain();
    do_op(3'd2, 8'h00, 8'hFF); drain();

    // ADD pulsed on the 4th edge while MUL is busy must be ignored
    do_op(3'd2, 8'd10, 8'd10);
    repeat (2) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.op = 3'd0; bus.a = 8'h11; bus.b = 8'h22;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("busy_during_ignored", bus.busy, 1);
    // wait for the done cycle and issue the next start inside it
    for (int i = 0; i < 40 && !bus.done; i++) @(negedge clk);
    check("b2b_done_seen", bus.done, 1);
    do_op(3'd1, 8'h10, 8'h01);
    drain();

    // reset in the middle of a divide
    do_op(3'd3, 8'd200, 8'd7);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_done", bus.done, 0);
    check("mid_rst_result", bus.result, 0);
    check("mid_rst_err", bus.err, 0);
    sb.delete();
    begin
      int done_before;
      done_before = n_done;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      check("no_done_after_rst", n_done, done_before);
    end
    do_op(3'd0, 8'h21, 8'h43); drain();

    repeat (30) begin
      do_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom_range(0, 3) == 0 ? 0 : $urandom));
      drain();
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/iter_calc_core.md
Name: iter_calc_core

Overview:
- Parametrised successor to the top-level calculator datapath.
- Accepts two WIDTH-bit unsigned operands and a 3-bit opcode under a start/busy/done handshake, and returns a 2*WIDTH-bit result plus an error flag.
- Single-cycle ops: add, sub, logic. Multi-cycle iterative ops: shift-add multiply and restoring divide.
- Sits between the pin-mapping wrapper, which latches operands from ui_in/uio_in, and the output muxing onto uo_out/uio_out.

Parameters:
WIDTH, 16, operand width in bits (legal range 4..32); result width is 2*WIDTH.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
op  input  3  opcode, sampled with start
a  input  WIDTH  operand A (unsigned), sampled with start
b  input  WIDTH  operand B (unsigned), sampled with start
busy  output  1  high while an accepted operation is in progress
done  output  1  one-cycle pulse when result/err become valid
result  output  2*WIDTH  registered result, held until next accepted start
err  output  1  registered error flag, valid with done, held like result

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, result=0, err=0, iteration counter=0. Reset asserted mid-operation aborts it; no done pulse follows.
- Opcodes:
  - 000 ADD: result = zero-extended a+b; carry appears in bit WIDTH.
  - 001 SUB: result[WIDTH-1:0] = (a-b) mod 2^WIDTH; result[WIDTH] = 1 iff a<b; upper bits 0.
  - 010 MUL: unsigned full product, a*b.
  - 011 DIV: result = {remainder, quotient}; remainder in upper WIDTH bits.
  - 100 AND, 101 OR, 110 XOR: result = zero-extended bitwise op.
  - 111: reserved.
- States: IDLE, EXEC, ITER, FIN.
- IDLE: on a clock edge with start=1, latch a, b, op; clear done; set busy=1. Next state is EXEC, or ITER for MUL/DIV with b!=0. result/err are not changed at acceptance.
- EXEC (single-cycle ops, DIV-by-zero, reserved op): at the next edge write result/err, pulse done=1, busy=0, return to IDLE.
  - Latency: done is high in the cycle after the 2nd edge, counting the accepting edge as edge 1.
- ITER: counter loaded with WIDTH on acceptance. One shift-add (MUL) or restore-subtract (DIV) step per edge; decrement counter. When counter reaches 0, go to FIN.
- FIN: at the next edge write result, err=0, done=1, busy=0, go to IDLE.
  - Latency: done is high after edge WIDTH+2, counting the accepting edge as edge 1.
- done is high for exactly one cycle. result/err are stable from that cycle until the next accepted start plus its completion.
- start while busy=1 is ignored; no queueing. Operand/opcode changes while busy have no effect.
- start high in the same cycle done is high is accepted (state is IDLE).
- Held start re-triggers: each IDLE cycle with start=1 begins a new operation.
- DIV with b==0: no iteration; err=1; result = {a, all-ones quotient}; EXEC latency applies.
- Reserved op 111: err=1, result=0, EXEC latency.
- err=0 for every other completed operation, including a SUB borrow and an ADD carry.
- All arithmetic is unsigned; no overflow is possible in the 2*WIDTH-bit result.
- busy and done are never both high.

Test Plan:
- WIDTH=8, ADD a=0xFF b=0x01 -> done 2 edges after accept; result=0x0100, err=0. SUB a=0x03 b=0x05 -> result=0x01FE, err=0.
- WIDTH=8, MUL a=200 b=3 -> busy for 9 edges; done pulse at edge 10; result=0x0258. MUL a=0xFF b=0xFF -> result=0xFE01.
- WIDTH=8, DIV a=200 b=7 -> result=0x041C (rem 4, quo 28), err=0, latency 10 edges. DIV a=5 b=9 -> result=0x0500.
- WIDTH=8, DIV a=0x42 b=0 -> err=1, result=0x42FF, done 2 edges after accept. Next ADD 1+1 -> err=0, result=0x0002.
- Start MUL 10*10. Pulse start with ADD at edge 4 while busy -> ignored; result=0x0064. Start issued during the done cycle -> accepted back-to-back.
- Start DIV 200/7. Assert rst_n low at edge 5 -> busy=0, done=0, result=0, err=0 immediately. No done pulse after release. A fresh ADD completes normally.
